// File: rtl/code_patch_bus_wrap.sv
// rtl/code_patch_bus_wrap.sv - CPU read-port wrapper around the code patch core, one outstanding transaction
//
// Purpose:
//   Accepts a CPU read and presents its address to the patch core. If the core
//   signals no-propagation, the core data is returned directly. Otherwise the
//   wrapper issues one memory read at the core-supplied address. The memory
//   return data goes back through the core so it can be data-patched.
//   Saturating debug counters track completed responses and no-propagation hits.
//
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   cpu_req_i/cpu_addr_i/cpu_gnt_o     CPU request handshake
//   cpu_rvalid_o/cpu_rdata_o/cpu_err_o CPU one-cycle response
//   core_*                             combinational patch core interface
//   mem_req_o/mem_addr_o/mem_gnt_i     memory request handshake
//   mem_rvalid_i/mem_rdata_i/mem_err_i memory response
//   cnt_clr_i, txn_cnt_o, nopg_cnt_o   statistics counters and clear
module code_patch_bus_wrap #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_req_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_err_o,
    output logic [ADDR_WIDTH-1:0] core_addr_o,
    output logic                  core_read_o,
    output logic [DATA_WIDTH-1:0] core_mi_data_o,
    input  logic [ADDR_WIDTH-1:0] core_mi_addr_i,
    input  logic [DATA_WIDTH-1:0] core_si_data_i,
    input  logic                  core_nopg_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    input  logic                  cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  txn_cnt_o,
    output logic [CNT_WIDTH-1:0]  nopg_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        RESP
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  nopg_q;
    logic [CNT_WIDTH-1:0]  txn_cnt_q;
    logic [CNT_WIDTH-1:0]  nopg_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            maddr_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            nopg_q     <= 1'b0;
            txn_cnt_q  <= '0;
            nopg_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i) begin
                        addr_q  <= cpu_addr_i;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (core_nopg_i) begin
                        rdata_q <= core_si_data_i;
                        err_q   <= 1'b0;
                        nopg_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        maddr_q <= core_mi_addr_i;
                        state_q <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // Memory data reaches the core combinationally, so the
                    // patched result is already on core_si_data_i here.
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_err_i ? '0 : core_si_data_i;
                        err_q   <= mem_err_i;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    nopg_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Clear wins over a coincident increment; both counters stick at all-ones.
            if (cnt_clr_i) begin
                txn_cnt_q  <= '0;
                nopg_cnt_q <= '0;
            end else if (state_q == RESP) begin
                if (txn_cnt_q != '1) begin
                    txn_cnt_q <= txn_cnt_q + CNT_WIDTH'(1);
                end
                if (nopg_q && (nopg_cnt_q != '1)) begin
                    nopg_cnt_q <= nopg_cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Outputs are forced low while reset is held, even before the first
    // reset edge has cleared the registers.
    assign cpu_gnt_o      = rst_ni && (state_q == IDLE);
    assign cpu_rvalid_o   = rst_ni && (state_q == RESP);
    assign cpu_rdata_o    = rst_ni ? rdata_q : '0;
    assign cpu_err_o      = rst_ni && err_q;
    assign core_addr_o    = addr_q;
    assign core_read_o    = rst_ni && ((state_q == LOOKUP) || (state_q == MEM_REQ) ||
                                       (state_q == MEM_WAIT));
    assign core_mi_data_o = mem_rdata_i;
    assign mem_req_o      = rst_ni && (state_q == MEM_REQ);
    assign mem_addr_o     = maddr_q;
    assign txn_cnt_o      = rst_ni ? txn_cnt_q : '0;
    assign nopg_cnt_o     = rst_ni ? nopg_cnt_q : '0;

endmodule

// File: tb/tb_code_patch_bus_wrap.sv
// tb/tb_code_patch_bus_wrap.sv - scoreboard bench for code_patch_bus_wrap with core and memory models
module tb_code_patch_bus_wrap;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          cpu_req_i;
    logic [AW-1:0] cpu_addr_i;
    logic          cpu_gnt_o;
    logic          cpu_rvalid_o;
    logic [DW-1:0] cpu_rdata_o;
    logic          cpu_err_o;
    logic [AW-1:0] core_addr_o;
    logic          core_read_o;
    logic [DW-1:0] core_mi_data_o;
    logic [AW-1:0] core_mi_addr_i;
    logic [DW-1:0] core_si_data_i;
    logic          core_nopg_i;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_err_i;
    logic          cnt_clr_i;
    logic [CW-1:0] txn_cnt_o;
    logic [CW-1:0] nopg_cnt_o;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    code_patch_bus_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_gnt_o(cpu_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_err_o(cpu_err_o),
        .core_addr_o(core_addr_o), .core_read_o(core_read_o), .core_mi_data_o(core_mi_data_o),
        .core_mi_addr_i(core_mi_addr_i), .core_si_data_i(core_si_data_i), .core_nopg_i(core_nopg_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .cnt_clr_i(cnt_clr_i), .txn_cnt_o(txn_cnt_o), .nopg_cnt_o(nopg_cnt_o)
    );

    // Behavioural patch core and memory contents, as plain address functions.
    function automatic logic f_nopg(input logic [31:0] a, input logic en);
        return en && (a[7:4] == 4'hF);
    endfunction
    function automatic logic [31:0] f_nopg_data(input logic [31:0] a);
        return 32'h13 + {8'h0, a[31:8]};
    endfunction
    function automatic logic [31:0] f_map(input logic [31:0] a, input logic en);
        return (en && (a[31:8] == 24'h1)) ? (32'h8000 | {24'h0, a[7:0]}) : a;
    endfunction
    function automatic logic [31:0] f_patch(input logic [31:0] a, input logic [31:0] d, input logic en);
        return (en && a[9]) ? (d ^ 32'h0F0F_0F0F) : d;
    endfunction
    function automatic logic f_mem_err(input logic [31:0] m);
        return m[31:28] == 4'hE;
    endfunction
    function automatic logic [31:0] f_mem_data(input logic [31:0] m);
        if (m == 32'h100) return 32'hDEAD_BEEF;
        if (m[31:28] == 4'hE) return 32'hFFFF_FFFF;
        return m * 32'h9E37_79B1 + 32'h1234;
    endfunction

    logic nopg_en, map_en, patch_en;

    assign core_nopg_i    = f_nopg(core_addr_o, nopg_en);
    assign core_mi_addr_i = f_map(core_addr_o, map_en);
    assign core_si_data_i = f_nopg(core_addr_o, nopg_en) ? f_nopg_data(core_addr_o)
                                                         : f_patch(core_addr_o, core_mi_data_o, patch_en);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } sb_t;
    sb_t sb_q[$];

    int resp_cnt = 0;
    int acc_cyc  = 0;

    // Monitor: every response must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cpu_rvalid_o) begin
                resp_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    sb_t it;
                    it = sb_q.pop_front();
                    chk("rdata", cpu_rdata_o, it.data);
                    chk("err", {31'd0, cpu_err_o}, {31'd0, it.err});
                    chk("latency", cyc - acc_cyc, it.lat);
                end
            end
        end
    end

    // Memory model with programmable grant stall and response delay.
    int          mem_gd = 0;
    int          mem_rd = 0;
    bit          stray = 1'b0;
    int          req_seen = 0;
    int          hold_cycles = 0;
    logic [31:0] last_maddr = '0;

    initial begin
        logic [31:0] m;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (stray) begin
                stray = 1'b0;
                mem_rvalid_i = 1'b1;
                mem_rdata_i = 32'hA5A5_A5A5;
                @(negedge clk);
                #1;
                mem_rvalid_i = 1'b0;
            end else if (mem_req_o) begin
                m = mem_addr_o;
                last_maddr = m;
                req_seen++;
                hold_cycles = 1;
                for (int k = 0; k < mem_gd; k++) begin
                    @(negedge clk);
                    #1;
                    chk("mem_req_hold", {31'd0, mem_req_o}, 32'd1);
                    chk("mem_addr_hold", mem_addr_o, m);
                    hold_cycles++;
                end
                mem_gnt_i = 1'b1;
                @(negedge clk);
                #1;
                mem_gnt_i = 1'b0;
                for (int k = 0; k < mem_rd; k++) begin
                    @(negedge clk);
                    #1;
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = f_mem_data(m);
                mem_err_i    = f_mem_err(m);
                @(negedge clk);
                #1;
                mem_rvalid_i = 1'b0;
                mem_err_i    = 1'b0;
                mem_rdata_i  = $urandom;
            end
        end
    end

    int exp_txn  = 0;
    int exp_nopg = 0;

    task automatic run_txn(input logic [31:0] a, input int gd, input int rd, input bit clr);
        sb_t         it;
        bit          nop;
        bit          got;
        logic [31:0] m;
        int          start;
        mem_gd = gd;
        mem_rd = rd;
        nop = f_nopg(a, nopg_en);
        if (nop) begin
            it = '{f_nopg_data(a), 1'b0, 2};
        end else begin
            m = f_map(a, map_en);
            if (f_mem_err(m)) it = '{32'h0, 1'b1, 4 + gd + rd};
            else              it = '{f_patch(a, f_mem_data(m), patch_en), 1'b0, 4 + gd + rd};
        end
        sb_q.push_back(it);
        start = resp_cnt;
        @(negedge clk);
        cpu_req_i = 1'b1;
        cpu_addr_i = a;
        #2;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cpu_gnt_o) begin got = 1'b1; break; end
            @(negedge clk);
            #2;
        end
        chk("accept", {31'd0, got}, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        cpu_req_i = 1'b0;
        cpu_addr_i = $urandom;
        #2;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (resp_cnt != start) begin got = 1'b1; break; end
            @(negedge clk);
            #2;
        end
        chk("resp_seen", {31'd0, got}, 32'd1);
        if (clr) begin
            cnt_clr_i = 1'b1;
            exp_txn = 0;
            exp_nopg = 0;
        end else begin
            if (exp_txn < CMAX) exp_txn++;
            if (nop && exp_nopg < CMAX) exp_nopg++;
        end
        @(negedge clk);
        #2;
        cnt_clr_i = 1'b0;
        chk("txn_cnt", {24'd0, txn_cnt_o}, exp_txn);
        chk("nopg_cnt", {24'd0, nopg_cnt_o}, exp_nopg);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt", {31'd0, cpu_gnt_o}, 32'd0);
        chk("rst_rvalid", {31'd0, cpu_rvalid_o}, 32'd0);
        chk("rst_rdata", cpu_rdata_o, 32'd0);
        chk("rst_err", {31'd0, cpu_err_o}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_core_read", {31'd0, core_read_o}, 32'd0);
        chk("rst_txn_cnt", {24'd0, txn_cnt_o}, 32'd0);
        chk("rst_nopg_cnt", {24'd0, nopg_cnt_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          seen0;
        int          r0;
        rst_ni = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0; cnt_clr_i = 1'b0;
        nopg_en = 1'b0; map_en = 1'b0; patch_en = 1'b0;

        // Outputs under reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            chk_reset_outputs();
        end
        rst_ni = 1'b1;
        @(negedge clk);
        #2;
        chk("gnt_after_reset", {31'd0, cpu_gnt_o}, 32'd1);

        // Identity core, immediate grant.
        run_txn(32'h0000_0100, 0, 0, 1'b0);
        chk("pass_maddr", last_maddr, 32'h0000_0100);

        // Address substitution with a 5-cycle grant stall.
        map_en = 1'b1;
        run_txn(32'h0000_0100, 5, 0, 1'b0);
        chk("patch_maddr", last_maddr, 32'h0000_8000);
        chk("patch_hold", hold_cycles, 32'd6);

        // No-propagation hit, then a stray memory response in IDLE.
        nopg_en = 1'b1;
        seen0 = req_seen;
        run_txn(32'h0000_00F0, 0, 0, 1'b0);
        chk("nopg_no_mem_req", req_seen, seen0);
        r0 = resp_cnt;
        stray = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("stray_ignored", resp_cnt, r0);
        chk("stray_gnt", {31'd0, cpu_gnt_o}, 32'd1);

        // Memory error with a data patch active on the address.
        patch_en = 1'b1;
        run_txn(32'hE000_0200, 1, 2, 1'b0);

        // Randomized mix against the reference model.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[7:4] = 4'hF;
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'h1;
            if ($urandom_range(0, 4) == 0) a[31:28] = 4'hE;
            run_txn(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        // Drive both counters into saturation.
        for (int n = 0; n < 260; n++) begin
            run_txn(32'h0000_00F0, 0, 0, 1'b0);
        end
        chk("sat_txn", {24'd0, txn_cnt_o}, 32'hFF);
        chk("sat_nopg", {24'd0, nopg_cnt_o}, 32'hFF);

        // Clear coincident with RESP, then one more transaction.
        run_txn(32'h0000_00F0, 0, 0, 1'b1);
        run_txn(32'h0000_0300, 0, 1, 1'b0);
        chk("after_clr_txn", {24'd0, txn_cnt_o}, 32'd1);

        // Reset while in MEM_WAIT; the late memory response must be ignored.
        sb_q.push_back('{32'h0, 1'b0, 0});
        mem_gd = 0;
        mem_rd = 8;
        @(negedge clk);
        cpu_req_i = 1'b1;
        cpu_addr_i = 32'h0000_0300;
        #2;
        chk("rst_test_accept", {31'd0, cpu_gnt_o}, 32'd1);
        @(negedge clk);
        cpu_req_i = 1'b0;
        repeat (2) @(negedge clk);
        r0 = resp_cnt;
        rst_ni = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_reset_outputs();
            @(negedge clk);
        end
        rst_ni = 1'b1;
        sb_q.delete();
        exp_txn = 0;
        exp_nopg = 0;
        @(negedge clk);
        #2;
        chk("gnt_after_mid_reset", {31'd0, cpu_gnt_o}, 32'd1);
        repeat (15) @(negedge clk);
        #2;
        chk("dropped_txn", resp_cnt, r0);
        chk("mid_reset_txn_cnt", {24'd0, txn_cnt_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
